// File: rtl/simple_processor_pkg.sv
// Shared definitions for the simple multicycle processor: widths, opcodes,
// step encodings, ALU operations and bus-select codes.
package simple_processor_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int IMM_W  = 10;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND} alu_op_t;

  // Bit 3 set selects a GPR whose index is carried in bits [2:0].
  typedef logic [3:0] bus_sel_t;
  localparam bus_sel_t SEL_NONE = 4'h0;
  localparam bus_sel_t SEL_IMM  = 4'h1;
  localparam bus_sel_t SEL_G    = 4'h2;
  localparam bus_sel_t SEL_R0   = 4'h8;
  localparam bus_sel_t SEL_R1   = 4'h9;
  localparam bus_sel_t SEL_R2   = 4'hA;
  localparam bus_sel_t SEL_R3   = 4'hB;
  localparam bus_sel_t SEL_R4   = 4'hC;
  localparam bus_sel_t SEL_R5   = 4'hD;
  localparam bus_sel_t SEL_R6   = 4'hE;
  localparam bus_sel_t SEL_R7   = 4'hF;

  function automatic bus_sel_t sel_reg(input logic [2:0] idx);
    return {1'b1, idx};
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/simple_processor_control_unit.sv
// Step counter plus decode of (step, IR) into bus select, register write
// enables, A/G load enables and ALU operation.
module simple_processor_control_unit
  import simple_processor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ir,
  output logic              ir_en,
  output bus_sel_t          bus_sel,
  output logic [NREGS-1:0]  reg_we,
  output logic              a_en,
  output logic              g_en,
  output alu_op_t           alu_op
);

  step_t step_q, step_d;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_arith;

  assign opcode   = ir[15:13];
  assign rx       = ir[12:10];
  assign ry       = ir[9:7];
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= T0;
    else     step_q <= step_d;
  end

  // Free-running window: every instruction takes exactly four steps.
  always_comb begin
    step_d = step_t'(step_q + 2'd1);
  end

  always_comb begin
    ir_en   = 1'b0;
    bus_sel = SEL_NONE;
    reg_we  = '0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    alu_op  = ALU_ADD;
    unique case (step_q)
      T0: ir_en = 1'b1;
      T1: begin
        if (opcode == OP_MV) begin
          bus_sel    = sel_reg(ry);
          reg_we[rx] = 1'b1;
        end else if (opcode == OP_LDI) begin
          bus_sel    = SEL_IMM;
          reg_we[rx] = 1'b1;
        end else if (opcode == OP_OUT) begin
          bus_sel = sel_reg(rx);
        end else if (is_arith) begin
          bus_sel = sel_reg(rx);
          a_en    = 1'b1;
        end
      end
      T2: begin
        if (is_arith) begin
          bus_sel = sel_reg(ry);
          g_en    = 1'b1;
          if (opcode == OP_SUB)      alu_op = ALU_SUB;
          else if (opcode == OP_AND) alu_op = ALU_AND;
          else                       alu_op = ALU_ADD;
        end
      end
      T3: begin
        if (is_arith) begin
          bus_sel    = SEL_G;
          reg_we[rx] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/simple_processor.sv
// Multicycle 16-bit processor datapath: eight GPRs, A and G registers, ALU,
// immediate sign extender and the shared bus mux, exported as 'bus'.
module simple_processor
  import simple_processor_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] iin,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] regs [NREGS];

  logic              ir_en;
  bus_sel_t          bus_sel;
  logic [NREGS-1:0]  reg_we;
  logic              a_en;
  logic              g_en;
  alu_op_t           alu_op;

  simple_processor_control_unit u_ctrl (
    .clk     (clock),
    .rst     (resetn),
    .ir      (ir_q),
    .ir_en   (ir_en),
    .bus_sel (bus_sel),
    .reg_we  (reg_we),
    .a_en    (a_en),
    .g_en    (g_en),
    .alu_op  (alu_op)
  );

  assign imm_ext = sext_imm(ir_q[IMM_W-1:0]);

  always_comb begin
    bus = '0;
    if (bus_sel[3]) begin
      bus = regs[bus_sel[2:0]];
    end else begin
      case (bus_sel)
        SEL_IMM: bus = imm_ext;
        SEL_G:   bus = g_q;
        default: bus = '0;
      endcase
    end
  end

  always_comb begin
    unique case (alu_op)
      ALU_SUB: alu_y = a_q - bus;
      ALU_AND: alu_y = a_q & bus;
      default: alu_y = a_q + bus;
    endcase
  end

  always_comb begin
    ir_d = ir_en ? iin   : ir_q;
    a_d  = a_en  ? bus   : a_q;
    g_d  = g_en  ? alu_y : g_q;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      ir_q <= '0;
      a_q  <= '0;
      g_q  <= '0;
    end else begin
      ir_q <= ir_d;
      a_q  <= a_d;
      g_q  <= g_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_gpr
      logic [DATA_W-1:0] r_q, r_d;

      always_comb begin
        r_d = reg_we[gi] ? bus : r_q;
      end

      always_ff @(posedge clock or posedge resetn) begin
        if (resetn) r_q <= '0;
        else        r_q <= r_d;
      end

      assign regs[gi] = r_q;
    end
  endgenerate

endmodule

// File: tb/tb_simple_processor.sv
// Scoreboard bench: a reference model predicts the bus value of every step of
// each instruction; the bus is sampled on the falling edge and compared.
module tb_simple_processor;

  logic        clock;
  logic        resetn;
  logic [15:0] iin;
  logic [15:0] bus;

  simple_processor dut (
    .clock  (clock),
    .resetn (resetn),
    .iin    (iin),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #1 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_r [8];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic sample_step();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", bus, 16'hxxxx);
    end else begin
      e = sb.pop_front();
      check(e.tag, bus, e.val);
    end
  endtask

  // Entered on a falling edge where the DUT sits at T0.
  task automatic run_instr(input logic [15:0] instr, input int nsteps);
    logic [15:0] e [4];
    logic [2:0]  op, rx, ry;
    logic [15:0] res;
    bit          wr;
    exp_t        item;
    op  = instr[15:13];
    rx  = instr[12:10];
    ry  = instr[9:7];
    e   = '{default: 16'h0000};
    res = 16'h0000;
    wr  = 1'b0;
    case (op)
      3'b000: begin res = model_r[ry]; e[1] = res; wr = 1'b1; end
      3'b001: begin e[1] = model_r[rx]; e[2] = model_r[ry]; res = model_r[rx] - model_r[ry]; e[3] = res; wr = 1'b1; end
      3'b010: begin e[1] = model_r[rx]; e[2] = model_r[ry]; res = model_r[rx] + model_r[ry]; e[3] = res; wr = 1'b1; end
      3'b011: begin e[1] = model_r[rx]; e[2] = model_r[ry]; res = model_r[rx] & model_r[ry]; e[3] = res; wr = 1'b1; end
      3'b100: e[1] = model_r[rx];
      3'b101: begin res = {{6{instr[9]}}, instr[9:0]}; e[1] = res; wr = 1'b1; end
      default: ;
    endcase
    for (int k = 0; k < nsteps; k++) begin
      item.tag = $sformatf("instr_%h_T%0d", instr, k);
      item.val = e[k];
      sb.push_back(item);
    end
    if (wr && nsteps == 4) model_r[rx] = res;

    iin = instr;
    sample_step();
    for (int k = 1; k < nsteps; k++) begin
      @(negedge clock);
      sample_step();
    end
    if (nsteps == 4) @(negedge clock);
    $display("instr %h steps %0d bus_last %h", instr, nsteps, bus);
  endtask

  task automatic apply_reset();
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) model_r[i] = 16'h0000;
    repeat (4) begin
      @(negedge clock);
      check("bus_in_reset", bus, 16'h0000);
    end
    resetn = 1'b0;
    $display("reset released at %0t", $time);
  endtask

  task automatic dump_regs();
    for (int i = 0; i < 8; i++) run_instr({3'b100, 3'(i), 10'h000}, 4);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iin    = 16'h0000;
    resetn = 1'b1;
    apply_reset();
    dump_regs();

    run_instr(16'hA01C, 4);  // ldi r0,#28
    run_instr(16'hA40A, 4);  // ldi r1,#10
    run_instr(16'h2080, 4);  // sub r0,r1 -> 0x0012
    run_instr(16'h8000, 4);  // out r0
    run_instr(16'hABFF, 4);  // ldi r2,#-1
    run_instr(16'h4900, 4);  // add r2,r2 -> 0xFFFE
    run_instr(16'h8800, 4);  // out r2
    run_instr(16'hADFF, 4);  // ldi r3,#511
    run_instr(16'hB200, 4);  // ldi r4,#-512
    run_instr(16'h1600, 4);  // mv r5,r4
    run_instr(16'h7580, 4);  // and r5,r3 -> 0
    run_instr(16'h2900, 4);  // sub r2,r2 -> 0
    run_instr(16'hBC01, 4);  // ldi r7,#1
    run_instr(16'h3B80, 4);  // sub r6,r7 -> 0xFFFF
    run_instr(16'hC000, 4);  // nop
    run_instr(16'hFFFF, 4);  // nop
    dump_regs();

    for (int n = 0; n < 40; n++) run_instr(16'($urandom), 4);
    dump_regs();

    // Abort a sub at T2: rx must not be written and the window restarts.
    run_instr(16'hA01C, 4);
    run_instr(16'hA40A, 4);
    run_instr(16'h2080, 3);
    apply_reset();
    dump_regs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
